// File: rtl/seconds_timer_ctrl_pkg.sv
// Shared definitions for the seconds countdown controller and its tick generator.
package seconds_timer_ctrl_pkg;

    // Controller state encoding. It is also visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Default width of the seconds counter.
    localparam int CNT_W_DEFAULT = 16;

endpackage : seconds_timer_ctrl_pkg

// File: rtl/seconds_timer_ctrl_rise_edge.sv
// 1-bit rising-edge detector. The input must already be synchronous to clk.
// rise is high for exactly one cycle when din goes from 0 to 1. It stays low
// for as long as din is held high afterwards.
module seconds_timer_ctrl_rise_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;

    // Keep last cycle's input value so a 0->1 transition can be seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule : seconds_timer_ctrl_rise_edge

// File: rtl/seconds_timer_ctrl.sv
// Countdown controller that sequences the 1 Hz clock-enable generator.
// - It loads a seconds count on start and decrements it on each tick_en.
// - It supports pause and resume, and abort.
// - It pulses done when the count reaches zero.
// - It pulses tick_clr on start and on resume, so the prescaler restarts and
//   the first counted second is a full second.
//
// Interface timing: there is no valid/ready handshake.
// - tick_en is a single-cycle strobe. It is acted on only in the cycle it is high.
// - start and pause are synchronous levels. Only their rising edge is an event.
// - abort is a level and is acted on in every cycle it is high.
// - All outputs change on the clk edge that samples the first high cycle of the
//   input that caused the change.
module seconds_timer_ctrl
    import seconds_timer_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic             tick_clr,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [1:0]       state
);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] rem_q, rem_n;
    logic             done_q, done_n;
    logic             clr_q, clr_n;
    logic             start_rise;
    logic             pause_rise;

    seconds_timer_ctrl_rise_edge u_start_edge (
        .clk   (clk),
        .reset (reset),
        .din   (start),
        .rise  (start_rise)
    );

    seconds_timer_ctrl_rise_edge u_pause_edge (
        .clk   (clk),
        .reset (reset),
        .din   (pause),
        .rise  (pause_rise)
    );

    // State and output registers. Every output comes from this flop set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            rem_q   <= rem_n;
            done_q  <= done_n;
            clr_q   <= clr_n;
        end
    end

    // Next state, with events prioritised abort > pause > start > tick.
    // done and tick_clr default to 0, so each one is a single-cycle pulse.
    always_comb begin
        state_n = state_q;
        rem_n   = rem_q;
        done_n  = 1'b0;
        clr_n   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    // From DONE, abort returns to IDLE. In IDLE it changes nothing.
                    state_n = ST_IDLE;
                    rem_n   = '0;
                end else if (start_rise) begin
                    if (load_val != '0) begin
                        rem_n   = load_val;
                        state_n = ST_RUN;
                        clr_n   = 1'b1;
                    end else begin
                        rem_n   = '0;
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    rem_n   = '0;
                end else if (pause_rise) begin
                    // A tick in the same cycle is dropped.
                    state_n = ST_PAUSE;
                end else if (tick_en) begin
                    if (rem_q == CNT_W'(1)) begin
                        rem_n   = '0;
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        rem_n = rem_q - CNT_W'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    rem_n   = '0;
                end else if (start_rise) begin
                    state_n = ST_RUN;
                    clr_n   = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                rem_n   = '0;
            end
        endcase
    end

    assign state     = state_q;
    assign remaining = rem_q;
    assign done      = done_q;
    assign tick_clr  = clr_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign paused    = (state_q == ST_PAUSE);

endmodule : seconds_timer_ctrl

// File: tb/tb_seconds_timer_ctrl.sv
// Bench for seconds_timer_ctrl.
// - The driver sets the inputs on the falling edge of clk.
// - The driver steps a reference model of the timer and queues the outputs
//   expected after the next rising edge.
// - The monitor takes one entry from the queue each cycle, just after the
//   rising edge, and compares it with the DUT outputs.
module tb_seconds_timer_ctrl;

    localparam int W = 22;  // {state[1:0], remaining[15:0], busy, paused, done, tick_clr}

    logic        clk;
    logic        reset;
    logic        tick_en;
    logic [15:0] load_val;
    logic        start;
    logic        pause;
    logic        abort;
    logic        tick_clr;
    logic [15:0] remaining;
    logic        busy;
    logic        paused;
    logic        done;
    logic [1:0]  state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_cycle  = 0;

    // Reference model: a mode name, a seconds count, and the previous levels of start and pause.
    typedef enum int {M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3} mode_t;
    mode_t m_mode;
    int    m_cnt;
    bit    m_sq, m_pq, m_done, m_clr;

    seconds_timer_ctrl #(.CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_en   (tick_en),
        .load_val  (load_val),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .tick_clr  (tick_clr),
        .remaining (remaining),
        .busy      (busy),
        .paused    (paused),
        .done      (done),
        .state     (state)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] model_vec();
        logic [1:0]  s;
        logic [15:0] c;
        s = 2'(int'(m_mode));
        c = 16'(m_cnt);
        return {s, c, (m_mode == M_RUN || m_mode == M_PAUSE), (m_mode == M_PAUSE), m_done, m_clr};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {state, remaining, busy, paused, done, tick_clr};
    endfunction

    // One clock of the timer, applied to the model.
    task automatic model_step(input bit rs, input bit st, input bit pa, input bit ab,
                              input bit tk, input int ld);
        bit sr, pr;
        if (!rs) begin
            m_mode = M_IDLE; m_cnt = 0; m_sq = 0; m_pq = 0; m_done = 0; m_clr = 0;
            return;
        end
        sr = st && !m_sq;
        pr = pa && !m_pq;
        m_sq = st;
        m_pq = pa;
        m_done = 0;
        m_clr  = 0;
        if (ab) begin
            if (m_mode != M_IDLE) begin
                m_mode = M_IDLE;
                m_cnt  = 0;
            end
        end else if (m_mode == M_RUN) begin
            if (pr) begin
                m_mode = M_PAUSE;
            end else if (tk) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_mode = M_DONE;
                    m_done = 1;
                end
            end
        end else if (m_mode == M_PAUSE) begin
            if (sr) begin
                m_mode = M_RUN;
                m_clr  = 1;
            end
        end else if (sr) begin
            m_cnt = ld;
            if (ld == 0) begin
                m_mode = M_DONE;
                m_done = 1;
            end else begin
                m_mode = M_RUN;
                m_clr  = 1;
            end
        end
    endtask

    // Driver: apply one cycle of inputs and queue the expected outputs.
    task automatic cyc(input bit rs, input bit st, input bit pa, input bit ab,
                       input bit tk, input int ld);
        @(negedge clk);
        reset    = rs;
        start    = st;
        pause    = pa;
        abort    = ab;
        tick_en  = tk;
        load_val = 16'(ld);
        model_step(rs, st, pa, ab, tk, ld);
        exp_q.push_back(model_vec());
    endtask

    task automatic idle_cycles(input int n, input int ld);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, ld);
    endtask

    // Assert reset between clock edges. Outputs must clear without waiting for a clock edge.
    task automatic async_reset();
        @(negedge clk);
        start = 0; pause = 0; abort = 0; tick_en = 0;
        model_step(0, 0, 0, 0, 0, 0);
        exp_q.push_back(model_vec());
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() == '0) n_pass++;
        else $display("FAIL async_reset: got %h required %h", dut_vec(), {W{1'b0}});
    endtask

    // Scoreboard monitor.
    initial begin
        logic [W-1:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            n_cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_vec();
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL cycle%0d outputs: got st=%0d rem=%0d busy=%0b paused=%0b done=%0b clr=%0b required st=%0d rem=%0d busy=%0b paused=%0b done=%0b clr=%0b",
                              n_cycle, a[21:20], a[19:4], a[3], a[2], a[1], a[0],
                              e[21:20], e[19:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    // Stimulus.
    initial begin
        reset = 0; start = 0; pause = 0; abort = 0; tick_en = 0; load_val = '0;
        model_step(0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (dut_vec() == '0) n_pass++;
        else $display("FAIL reset_state: got %h required %h", dut_vec(), {W{1'b0}});
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        idle_cycles(2, 0);

        // Count down 3 s with a tick every 5 cycles.
        cyc(1, 1, 0, 0, 0, 3);
        cyc(1, 0, 0, 0, 0, 3);
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, (i % 5) == 4, 3);
        idle_cycles(2, 3);

        // Pause at 5 s, ignore ticks while paused, resume, then tick once.
        cyc(1, 1, 0, 0, 0, 6);
        cyc(1, 0, 0, 0, 1, 6);
        cyc(1, 0, 1, 0, 0, 6);
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0, 1, 6);
        cyc(1, 1, 0, 0, 0, 6);
        cyc(1, 0, 0, 0, 0, 6);
        cyc(1, 0, 0, 0, 1, 6);
        cyc(1, 0, 0, 1, 0, 6);

        // Hold start high: one load only, and changes to load_val are ignored.
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, (i % 6) == 5, (i == 0) ? 7 : 2 + i);
        cyc(1, 0, 0, 1, 0, 0);

        // A load value of zero goes straight to DONE.
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle_cycles(2, 0);

        // Pause and tick in the same cycle at 5 s.
        cyc(1, 1, 0, 0, 0, 5);
        cyc(1, 0, 1, 0, 1, 5);
        cyc(1, 1, 0, 0, 0, 5);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 5);
        // Abort and tick in the same cycle at 1 s.
        cyc(1, 0, 0, 1, 1, 5);
        idle_cycles(2, 5);

        // Async reset in mid-count, then a normal 2 s count.
        cyc(1, 1, 0, 0, 0, 9);
        cyc(1, 0, 0, 0, 1, 9);
        async_reset();
        cyc(0, 0, 0, 0, 0, 2);
        cyc(1, 0, 0, 0, 0, 2);
        cyc(1, 1, 0, 0, 0, 2);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, (i % 3) == 2, 2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit st, pa, ab, tk;
            st = ($urandom_range(0, 7) == 0) ? !start : start;
            pa = ($urandom_range(0, 9) == 0) ? !pause : pause;
            ab = ($urandom_range(0, 59) == 0);
            tk = ($urandom_range(0, 3) == 0);
            // Keep a start rising edge in RUN away from tick_en.
            if (m_mode == M_RUN && st && !m_sq) tk = 0;
            cyc(1, st, pa, ab, tk, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12));
        end
        idle_cycles(1, 0);

        // Drain the queue within a bounded time.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d entries pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seconds_timer_ctrl
